// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle WIDTH-bit subtractor, diff = x - y - bin.
// Processes DIGIT bits per clock, LSB digit first, with a start/ready/done
// handshake. The datapath is DIGIT full-subtractor cells. The minuend shift
// register doubles as the result accumulator: each cycle one digit shifts
// out of the bottom and one difference digit shifts in at the top.
//
// Parameters:
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits per cycle; WIDTH must be a multiple of DIGIT
// Ports:
//   clk, rst_n    rising-edge clock, synchronous active-low reset
//   start         request, accepted only while ready=1
//   x, y, bin     minuend, subtrahend, borrow-in (sampled on accept)
//   ready         high in IDLE
//   busy          high in RUN
//   done          one-cycle pulse when diff/bout have just been loaded
//   diff, bout    registered result and final borrow-out
//   ovf           signed overflow flag, present only with SERIAL_SUB_OVF_EN
// Optional feature macro: SERIAL_SUB_OVF_EN

// One full-subtractor bit: d = x - y - b, with borrow-out.
module serial_subtractor_cell (
    input  logic i_x,
    input  logic i_y,
    input  logic i_b,
    output logic o_d,
    output logic o_b
);
    assign o_d = i_x ^ i_y ^ i_b;
    assign o_b = (~i_x & i_y) | (~i_x & i_b) | (i_y & i_b);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bout
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_subtractor: WIDTH must be a positive multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_b;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [DIGIT:0]   w_bc;
    logic [DIGIT-1:0] w_d;
    logic [WIDTH-1:0] w_d_ext;
    logic [WIDTH-1:0] w_x_nxt;
    logic             w_last;

    // Borrow ripples through the DIGIT cells; the register closes the loop
    // between cycles.
    assign w_bc[0] = r_b;

    genvar g;
    generate
        for (g = 0; g < DIGIT; g++) begin : g_cell
            serial_subtractor_cell u_cell (
                .i_x (r_x[g]),
                .i_y (r_y[g]),
                .i_b (w_bc[g]),
                .o_d (w_d[g]),
                .o_b (w_bc[g+1])
            );
        end
    endgenerate

    assign w_last = (r_cnt == CW'(N - 1));

    // Shift the consumed digit out, insert the new difference digit on top.
    // After N cycles r_x holds the full difference.
    always_comb begin
        w_d_ext              = '0;
        w_d_ext[DIGIT-1:0]   = w_d;
        w_x_nxt              = (r_x >> DIGIT) | (w_d_ext << (WIDTH - DIGIT));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ready       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because r_x is overwritten by
    // the difference as the operation proceeds.
    logic r_xm;
    logic r_ym;
    logic r_ovf;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_b    <= 1'b0;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_xm   <= 1'b0;
            r_ym   <= 1'b0;
            r_ovf  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x   <= x;
                        r_y   <= y;
                        r_b   <= bin;
                        r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        r_xm  <= x[WIDTH-1];
                        r_ym  <= y[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_x   <= w_x_nxt;
                    r_y   <= r_y >> DIGIT;
                    r_b   <= w_bc[DIGIT];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff <= w_x_nxt;
                        r_bout <= w_bc[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf  <= (r_xm != r_ym) & (w_x_nxt[WIDTH-1] != r_xm);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff = r_diff;
    assign bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor. Three instances (DIGIT = 1, 4, 8,
// WIDTH = 8) share operands but have separate start lines. Each issued
// operation pushes a model-computed expectation per enabled instance; a
// negedge monitor pops and compares whenever an instance pulses done.
module tb_serial_subtractor;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
        logic         o;
        int           acc;
        int           n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   start;
    logic [W-1:0] x, y;
    logic         bin;
    logic [2:0]   ready, busy, done, bout;
    logic [W-1:0] diff [3];
`ifdef SERIAL_SUB_OVF_EN
    logic [2:0]   ovf;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$], q1[$], q2[$];
    logic [W-1:0] prev_d [3];
    logic         prev_b [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .x(x), .y(y), .bin(bin),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]), .diff(diff[0]),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf[0]),
`endif
        .bout(bout[0]));
    serial_subtractor #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .x(x), .y(y), .bin(bin),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]), .diff(diff[1]),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf[1]),
`endif
        .bout(bout[1]));
    serial_subtractor #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .x(x), .y(y), .bin(bin),
        .ready(ready[2]), .busy(busy[2]), .done(done[2]), .diff(diff[2]),
`ifdef SERIAL_SUB_OVF_EN
        .ovf(ovf[2]),
`endif
        .bout(bout[2]));

    function automatic int nof(input int i);
        case (i)
            0: return 8;
            1: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (done[i]) begin
                    exp_t e;
                    bit   ok;
                    ok = 1'b0;
                    e  = '0;
                    case (i)
                        0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
                        1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
                        default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
                    endcase
                    if (!ok) begin
                        chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("diff%0d", i), 32'(diff[i]), 32'(e.d));
                        chk($sformatf("bout%0d", i), 32'(bout[i]), 32'(e.b));
                        chk($sformatf("latency%0d", i), 32'(cyc - e.acc), 32'(e.n));
`ifdef SERIAL_SUB_OVF_EN
                        chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(e.o));
`endif
                    end
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ready%0d", tag, i), 32'(ready[i]), 32'd1);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
            chk($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'd0);
            chk($sformatf("%s_diff%0d", tag, i), 32'(diff[i]), 32'd0);
            chk($sformatf("%s_bout%0d", tag, i), 32'(bout[i]), 32'd0);
        end
    endtask

    // Issue one operation to the instances in en. inj>0: pulse a second
    // start on instance 0 at that cycle (must be ignored). rst_at>0: pull
    // reset low at that cycle, discarding the operation.
    task automatic run_op(input logic [2:0] en, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input int inj, input int rst_at);
        int           r, acc, k;
        logic [W-1:0] md;
        logic         mb, mo;
        bit           rst_hit;
        exp_t         e;
        rst_hit = 1'b0;
        r  = int'(a) - int'(b) - int'(c);
        md = r[W-1:0];
        mb = (r < 0);
        mo = (a[W-1] != b[W-1]) && (md[W-1] != a[W-1]);
        @(negedge clk);
        x = a; y = b; bin = c; start = en;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = '0;
        x = W'($urandom); y = W'($urandom); bin = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            if (en[i]) begin
                e = '{d: md, b: mb, o: mo, acc: acc, n: nof(i)};
                case (i)
                    0: q0.push_back(e);
                    1: q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            k = cyc - acc;
            start = '0;
            if (rst_hit) begin
                if (!rst_n) begin
                    rst_n = 1'b1;
                    q0.delete(); q1.delete(); q2.delete();
                    check_idle("post_reset");
                    for (int i = 0; i < 3; i++) begin prev_d[i] = '0; prev_b[i] = 1'b0; end
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (en[i]) begin
                        chk($sformatf("busy%0d_c%0d", i, k), 32'(busy[i]), 32'(k < nof(i)));
                        chk($sformatf("ready%0d_c%0d", i, k), 32'(ready[i]), 32'(k > nof(i)));
                        chk($sformatf("hold_diff%0d_c%0d", i, k), 32'(diff[i]),
                            32'((k < nof(i)) ? prev_d[i] : md));
                        chk($sformatf("hold_bout%0d_c%0d", i, k), 32'(bout[i]),
                            32'((k < nof(i)) ? prev_b[i] : mb));
                    end
                end
                if (inj > 0 && k == inj) begin
                    x = 8'h10; y = 8'h01; bin = 1'b0; start[0] = 1'b1;
                end
                if (rst_at > 0 && k == rst_at) begin
                    rst_n   = 1'b0;
                    rst_hit = 1'b1;
                end
            end
        end
        if (!rst_hit) begin
            for (int i = 0; i < 3; i++) begin
                if (en[i]) begin prev_d[i] = md; prev_b[i] = mb; end
            end
        end
        chk("pending_expectations", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = '0; x = '0; y = '0; bin = 1'b0;
        for (int i = 0; i < 3; i++) begin prev_d[i] = '0; prev_b[i] = 1'b0; end
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        run_op(3'b111, 8'h05, 8'h03, 1'b0, 0, 0);
        run_op(3'b111, 8'h00, 8'h01, 1'b0, 0, 0);
        run_op(3'b111, 8'h00, 8'h00, 1'b1, 0, 0);
        run_op(3'b111, 8'hA7, 8'h58, 1'b1, 0, 0);
        run_op(3'b111, 8'h80, 8'h01, 1'b0, 0, 0);
        run_op(3'b111, 8'h05, 8'h03, 1'b0, 0, 0);
        run_op(3'b111, 8'hFF, 8'hFF, 1'b1, 0, 0);
        run_op(3'b111, 8'h7F, 8'h80, 1'b1, 0, 0);
        run_op(3'b111, 8'hFF, 8'h00, 1'b0, 0, 0);

        // Start pulse while busy must be dropped: only one done, diff=0x1F.
        run_op(3'b001, 8'h20, 8'h01, 1'b0, 3, 0);

        // Reset mid-operation discards it; then a fresh op completes.
        run_op(3'b111, 8'h55, 8'h22, 1'b0, 0, 3);
        run_op(3'b111, 8'h33, 8'h44, 1'b1, 0, 0);

        for (int n = 0; n < 30; n++) begin
            run_op(3'b111, W'($urandom), W'($urandom), 1'($urandom), 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, parametrised N-bit subtractor built from the bit-level full-subtractor equations. Computes diff = x - y - bin on WIDTH-bit operands, DIGIT bits per clock, LSB first, with a start/ready/done handshake. Used where area matters more than latency: a WIDTH-bit datapath costs only DIGIT borrow cells plus shift registers.

Parameters:
WIDTH, 8, operand/result width in bits; must be >= 1.
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (elaboration error otherwise).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  request; accepted only when ready=1
x  input  WIDTH  minuend, sampled on the accepting edge
y  input  WIDTH  subtrahend, sampled on the accepting edge
bin  input  1  borrow-in, sampled on the accepting edge
ready  output  1  high in IDLE only
busy  output  1  high in RUN only
done  output  1  one-cycle pulse, result valid
diff  output  WIDTH  registered result, x - y - bin mod 2^WIDTH
bout  output  1  registered final borrow-out

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, ready=1, busy=0, done=0, diff=0, bout=0, internal shift registers, borrow and digit counter cleared. Applies in any state. An in-flight operation is discarded, with no done pulse and no update of diff/bout.
- States:
  - IDLE: if start=1, latch x, y, bin and set counter=0, then go to RUN. Otherwise stay.
  - RUN: each cycle processes the next DIGIT bits, LSB digit first.
  - DONE: lasts one cycle, then goes to IDLE.
- Per-bit cell, chained DIGIT times per cycle with borrow b:
  - d = xi ^ yi ^ b
  - b' = (~xi & yi) | (~xi & b) | (yi & b)
- Borrow register carries between cycles and is initialised to bin.
- RUN lasts exactly N = WIDTH/DIGIT cycles. On the edge that computes the last digit:
  - diff and bout are loaded.
  - State goes to DONE.
- Latency: start sampled at edge k, so diff/bout update at edge k+N and done=1 for the cycle between edges k+N and k+N+1. ready returns to 1 after edge k+N+1.
- diff/bout hold their value until the next completed operation. They do not change while a new operation runs.
- start while busy or in DONE is ignored (not queued). x, y, bin may change freely after acceptance.
- WIDTH=DIGIT gives N=1: a single RUN cycle, fully parallel.
- bout=1 iff x < y + bin as unsigned values. Example: x=0, y=0, bin=1 gives diff = all ones, bout=1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit, registered, reset 0), updated on the same edge as diff. It flags two's-complement signed overflow: ovf = (x[MSB] != y[MSB]) & (diff[MSB] != x[MSB]), using the latched x/y. bin is included in diff as normal.
- Undefined: ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1: start with x=0x05, y=0x03, bin=0 -> done exactly 8 cycles after the accepting edge, diff=0x02, bout=0. busy=1 for 8 cycles; ready=0 from acceptance until after the done cycle.
- WIDTH=8, DIGIT=1: x=0x00, y=0x01, bin=0 -> diff=0xFF, bout=1. Then x=0x00, y=0x00, bin=1 -> diff=0xFF, bout=1.
- WIDTH=8, DIGIT=4: x=0xA7, y=0x58, bin=1 -> done after 2 cycles, diff=0x4E, bout=0. Repeat with WIDTH=8, DIGIT=8 -> done after 1 cycle, same result.
- Pulse start with x=0x10, y=0x01 while busy during a prior x=0x20, y=0x01 operation -> only one done, diff=0x1F, no second done.
- Assert rst_n=0 for one edge at cycle 4 of an 8-cycle operation (prior diff=0x1F) -> diff=0, bout=0, no done pulse, ready=1 on the next cycle. A new start then completes normally.
- SERIAL_SUB_OVF_EN defined, WIDTH=8, DIGIT=1: x=0x80, y=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1. Then x=0x05, y=0x03 -> ovf=0.
